// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared sizes and state encoding for program_memory (rev 1.0)
`default_nettype none

package cpu_mem_pkg;

  localparam int MEM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/program_memory_if.sv
// program_memory_if: CPU memory port, host load port and debug peek port (rev 1.0)
`default_nettype none

interface program_memory_if;
  import cpu_mem_pkg::*;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] memoryIn;
  logic [DATA_W-1:0] memoryOut;
  logic              cpu_reset;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  read, write, address, memoryIn,
    input  load_start, load_valid, load_data, dbg_addr,
    output memoryOut, cpu_reset, load_ready, load_done, dbg_data
  );

  modport master (
    output read, write, address, memoryIn,
    output load_start, load_valid, load_data, dbg_addr,
    input  memoryOut, cpu_reset, load_ready, load_done, dbg_data
  );

endinterface

`default_nettype wire

// File: rtl/mem16x8.sv
// mem16x8: 16x8 array, one synchronous write port, two asynchronous read ports (rev 1.0)
`default_nettype none

module mem16x8
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  // No reset: contents must survive a reset that aborts a load.
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/program_memory.sv
// program_memory: CPU program/data memory with host image loader that holds the CPU in reset while loading (rev 1.0)
`default_nettype none

module program_memory
  import cpu_mem_pkg::*;
#(
  parameter int LOAD_WORDS = 16
) (
  input  logic            clk,
  input  logic            reset,
  program_memory_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LOAD_WORDS - 1);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              load_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] cpu_rdata;

  assign load_accept = (state_q == LOAD) && bus.load_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    case (state_q)
      IDLE, RUN: begin
        if (bus.load_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
        end
      end
      LOAD: begin
        // Final byte leaves LOAD before the pointer could pass LAST_PTR.
        if (load_accept) begin
          if (wr_ptr_q == LAST_PTR) begin
            state_d  = RELEASE;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      RELEASE: state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.address;
    mem_wdata = bus.memoryIn;
    if (state_q == LOAD) begin
      mem_we    = bus.load_valid;
      mem_waddr = wr_ptr_q;
      mem_wdata = bus.load_data;
    end else if (state_q == RUN) begin
      mem_we    = bus.write;
    end
  end

  mem16x8 u_mem (
    .clk       (clk),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .raddr_a_i (bus.address),
    .rdata_a_o (cpu_rdata),
    .raddr_b_i (bus.dbg_addr),
    .rdata_b_o (bus.dbg_data)
  );

  assign bus.memoryOut  = ((state_q == RUN) && bus.read) ? cpu_rdata : '0;
  assign bus.cpu_reset  = (state_q != RUN);
  assign bus.load_ready = (state_q == LOAD);
  assign bus.load_done  = (state_q == RELEASE);

endmodule

`default_nettype wire

// File: tb/tb_program_memory.sv
// tb_program_memory: directed self-checking bench for program_memory (rev 1.0)
`default_nettype none

module tb_program_memory;
  import cpu_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_memory_if b ();
  program_memory_if b4 ();

  program_memory #(.LOAD_WORDS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  program_memory #(.LOAD_WORDS(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4.slave)
  );

  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } cpu_vec_t;

  cpu_vec_t cv [9];

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (b.load_done === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load16(input logic [7:0] base);
    b.load_start = 1'b1;
    tick();
    b.load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b.load_valid = 1'b1;
      b.load_data  = base + 8'(i);
      tick();
    end
    b.load_valid = 1'b0;
  endtask

  task automatic check_dbg16(input string name, input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      b.dbg_addr = 4'(i);
      #1;
      check($sformatf("%s[%0d]", name, i), b.dbg_data, base + 8'(i));
    end
  endtask

  initial begin
    int cyc;
    int idx;

    cv[0] = '{1'b0, 1'b1, 4'h3, 8'hA5, 8'h00};
    cv[1] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'hA5};
    cv[2] = '{1'b1, 1'b0, 4'h5, 8'h00, 8'h15};
    cv[3] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'h00};
    cv[4] = '{1'b1, 1'b1, 4'h7, 8'h3C, 8'h17};
    cv[5] = '{1'b1, 1'b0, 4'h7, 8'h00, 8'h3C};
    cv[6] = '{1'b1, 1'b0, 4'h0, 8'h00, 8'h10};
    cv[7] = '{1'b1, 1'b1, 4'hF, 8'h99, 8'h1F};
    cv[8] = '{1'b1, 1'b0, 4'hF, 8'h00, 8'h99};

    {b.read, b.write, b.address, b.memoryIn, b.load_start, b.load_valid, b.load_data, b.dbg_addr} = '0;
    {b4.read, b4.write, b4.address, b4.memoryIn, b4.load_start, b4.load_valid, b4.load_data, b4.dbg_addr} = '0;
    reset = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_cpu_reset", b.cpu_reset, 1);
    check("rst_load_ready", b.load_ready, 0);
    check("rst_load_done", b.load_done, 0);
    reset = 1'b1;
    b.read = 1'b1;
    #1;
    check("idle_read_gated", b.memoryOut, 8'h00);
    b.read = 1'b0;

    // Back-to-back 16-byte load
    b.load_start = 1'b1;
    tick();
    b.load_start = 1'b0;
    check("load_ready_entry", b.load_ready, 1);
    check("load_cpu_reset", b.cpu_reset, 1);
    for (int i = 0; i < 16; i++) begin
      b.load_valid = 1'b1;
      b.load_data  = 8'h10 + 8'(i);
      tick();
    end
    b.load_valid = 1'b0;
    check("release_done", b.load_done, 1);
    check("release_cpu_reset", b.cpu_reset, 1);
    check("release_ready", b.load_ready, 0);
    b.dbg_addr = 4'h5;
    #1;
    check("dbg5", b.dbg_data, 8'h15);
    tick();
    check("run_cpu_reset", b.cpu_reset, 0);
    check("run_done_low", b.load_done, 0);
    check("done_pulses", 8'(done_cnt), 8'd1);

    // CPU access table in RUN
    for (int i = 0; i < 9; i++) begin
      b.read     = cv[i].rd;
      b.write    = cv[i].wr;
      b.address  = cv[i].addr;
      b.memoryIn = cv[i].din;
      #1;
      check($sformatf("cpu_vec%0d", i), b.memoryOut, cv[i].exp);
      tick();
    end
    b.read  = 1'b0;
    b.write = 1'b0;

    // Stalled load from RUN: valid every other cycle
    b.load_start = 1'b1;
    tick();
    b.load_start = 1'b0;
    check("stall_cpu_reset", b.cpu_reset, 1);
    cyc = 0;
    idx = 0;
    while (b.load_ready === 1'b1 && cyc < 100) begin
      b.load_valid = (cyc % 2) == 1;
      b.load_data  = 8'h20 + 8'(idx);
      tick();
      if ((cyc % 2) == 1) idx++;
      cyc++;
    end
    b.load_valid = 1'b0;
    check("stall_cycles", 8'(cyc), 8'd32);
    check("stall_bytes", 8'(idx), 8'd16);
    check("stall_done", b.load_done, 1);
    check_dbg16("stall_mem", 8'h20);
    tick();

    // Reset mid-load after 6 bytes
    b.load_start = 1'b1;
    tick();
    b.load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b.load_valid = 1'b1;
      b.load_data  = 8'h50 + 8'(i);
      tick();
    end
    b.load_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_cpu_reset", b.cpu_reset, 1);
    check("abort_ready", b.load_ready, 0);
    for (int i = 0; i < 7; i++) begin
      b.dbg_addr = 4'(i);
      #1;
      check($sformatf("abort_mem[%0d]", i), b.dbg_data, (i < 6) ? 8'h50 + 8'(i) : 8'h26);
    end
    tick();
    reset = 1'b1;
    tick();
    check("abort_idle_ready", b.load_ready, 0);
    load16(8'hF0);
    check("reload_done", b.load_done, 1);
    check_dbg16("reload_mem", 8'hF0);
    tick();

    // LOAD_WORDS=4 instance: partial reload from RUN
    b4.load_start = 1'b1;
    tick();
    b4.load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b4.load_valid = 1'b1;
      b4.load_data  = 8'hA0 + 8'(i);
      tick();
    end
    b4.load_valid = 1'b0;
    check("lw4_done", b4.load_done, 1);
    tick();
    check("lw4_run", b4.cpu_reset, 0);
    for (int i = 0; i < 16; i++) begin
      b4.write    = 1'b1;
      b4.address  = 4'(i);
      b4.memoryIn = 8'h60 + 8'(i);
      tick();
    end
    b4.write = 1'b0;
    b4.load_start = 1'b1;
    tick();
    b4.load_start = 1'b0;
    check("lw4_stop_cpu", b4.cpu_reset, 1);
    check("lw4_ready", b4.load_ready, 1);
    for (int i = 0; i < 4; i++) begin
      b4.load_valid = 1'b1;
      b4.load_data  = 8'hC0 + 8'(i);
      tick();
    end
    b4.load_valid = 1'b0;
    check("lw4_done2", b4.load_done, 1);
    for (int i = 0; i < 16; i++) begin
      b4.dbg_addr = 4'(i);
      #1;
      check($sformatf("lw4_mem[%0d]", i), b4.dbg_data, (i < 4) ? 8'hC0 + 8'(i) : 8'h60 + 8'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
